// File: rtl/bin_to_bcd_4_pkg.sv
// bin_to_bcd_4_pkg: shared sizes, limits and FSM encoding for the BCD converter
package bin_to_bcd_4_pkg;
  localparam int N_BITS       = 14;
  localparam int N_DIGITS     = 4;
  localparam int MAX_VAL      = 9999;
  localparam int SHIFT_CYCLES = N_BITS;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/bin_to_bcd_4_digit_adj.sv
// bcd_digit_adj: double-dabble nibble correction, adds 3 when the digit is 5 or more
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  always_comb d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_4.sv
// bin_to_bcd_4: serial double-dabble converter with saturation at MAX_VAL
// Display outputs only change on the DONE-to-IDLE edge, so the scratch is never visible.
module bin_to_bcd_4 #(
  parameter int N_BITS   = bin_to_bcd_4_pkg::N_BITS,
  parameter int N_DIGITS = bin_to_bcd_4_pkg::N_DIGITS,
  parameter int MAX_VAL  = bin_to_bcd_4_pkg::MAX_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] bin,
  input  logic [3:0]        dot_in,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [3:0]        num3,
  output logic [3:0]        num2,
  output logic [3:0]        num1,
  output logic [3:0]        num0,
  output logic [3:0]        dot_out
);
  import bin_to_bcd_4_pkg::*;
  localparam int SW = 4 * N_DIGITS;
  localparam logic [N_BITS-1:0] MAX_V = N_BITS'(MAX_VAL);
  localparam logic [3:0] LAST = 4'(SHIFT_CYCLES - 1);
  state_e            state_q;
  logic [SW-1:0]     bcd_q;
  logic [SW-1:0]     bcd_adj;
  logic [N_BITS-1:0] sat_q;
  logic [3:0]        cnt_q;
  logic [3:0]        dot_q;
  logic              ovf_pend_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic [SW-1:0]     disp_q;
  logic [3:0]        dot_out_q;
  logic              over;
  always_comb over = bin > MAX_V;
  for (genvar d = 0; d < N_DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i(bcd_q[4*d +: 4]),
      .d_o(bcd_adj[4*d +: 4])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      sat_q      <= '0;
      cnt_q      <= '0;
      dot_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      dot_out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          sat_q      <= over ? MAX_V : bin;
          dot_q      <= dot_in;
          ovf_pend_q <= over;
          bcd_q      <= '0;
          cnt_q      <= '0;
          busy_q     <= 1'b1;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          // MSB of the binary operand enters scratch bit 0 after correction
          {bcd_q, sat_q} <= {bcd_adj[SW-2:0], sat_q, 1'b0};
          cnt_q          <= cnt_q + 4'd1;
          if (cnt_q == LAST) state_q <= DONE;
        end
        DONE: begin
          disp_q    <= bcd_q;
          dot_out_q <= dot_q;
          ovf_q     <= ovf_pend_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign num3    = disp_q[15:12];
  assign num2    = disp_q[11:8];
  assign num1    = disp_q[7:4];
  assign num0    = disp_q[3:0];
  assign dot_out = dot_out_q;
endmodule

// File: tb/tb_bin_to_bcd_4.sv
// tb_bin_to_bcd_4: directed vectors with a scoreboard queue checked on every done pulse
module tb_bin_to_bcd_4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic [3:0]  dot_in = '0;
  logic        busy, done, ovf;
  logic [3:0]  num3, num2, num1, num0, dot_out;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dot;
    logic        ovf;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  bin_to_bcd_4 dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .dot_in(dot_in),
    .busy(busy), .done(done), .ovf(ovf),
    .num3(num3), .num2(num2), .num1(num1), .num0(num0), .dot_out(dot_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; the following posedge samples start, done lands 16 negedges on.
  task automatic issue(input logic [13:0] b, input logic [3:0] d, input logic [15:0] ed,
                       input logic eo, input bit expect_done);
    exp_t e;
    bin = b;
    dot_in = d;
    start = 1'b1;
    if (expect_done) begin
      e.digits = ed;
      e.dot = d;
      e.ovf = eo;
      e.cyc = cyc + 16;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    chk("done_seen", 32'(done), 1);
  endtask

  always @(negedge clk) begin
    if (done) begin
      chk("done_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("digits", {num3, num2, num1, num0}, e.digits);
        chk("dot_out", dot_out, e.dot);
        chk("ovf", ovf, e.ovf);
        chk("latency", cyc, e.cyc);
        chk("digit_range", 32'(num3 <= 9 && num2 <= 9 && num1 <= 9 && num0 <= 9), 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] tb_bin [5] = '{14'd0, 14'd9999, 14'd10000, 14'd16383, 14'd5};
    logic [15:0] tb_dig [5] = '{16'h0000, 16'h9999, 16'h9999, 16'h9999, 16'h0005};
    logic        tb_ovf [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0]  tb_dot [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b1111, 4'b0000};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {busy, done, ovf, num3, num2, num1, num0, dot_out}, 0);
    end
    issue(14'd1234, 4'b0100, 16'h1234, 1'b0, 1'b1);
    wait_done();
    bin = 14'd777;
    dot_in = 4'b1111;
    repeat (5) @(negedge clk);
    chk("hold_digits", {num3, num2, num1, num0}, 16'h1234);
    chk("hold_dot", dot_out, 4'b0100);
    chk("hold_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      issue(tb_bin[i], tb_dot[i], tb_dig[i], tb_ovf[i], 1'b1);
      wait_done();
      @(negedge clk);
    end
    issue(14'd42, 4'b0000, 16'h0042, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_mid", busy, 1);
    issue(14'd7777, 4'b1111, 16'h7777, 1'b0, 1'b0);
    wait_done();
    repeat (30) @(negedge clk);
    chk("ignored_start", {num3, num2, num1, num0, dot_out}, {16'h0042, 4'b0000});
    issue(14'd8888, 4'b1010, 16'h8888, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {busy, done, ovf, num3, num2, num1, num0, dot_out}, 0);
    repeat (25) @(negedge clk);
    chk("abort_quiet", {busy, num3, num2, num1, num0}, 0);
    issue(14'd8888, 4'b1010, 16'h8888, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    issue(14'd1, 4'b0001, 16'h0001, 1'b0, 1'b1);
    wait_done();
    issue(14'd2, 4'b0010, 16'h0002, 1'b0, 1'b1);
    wait_done();
    issue(14'd3, 4'b0011, 16'h0003, 1'b0, 1'b1);
    wait_done();
    repeat (20) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
